// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect/halt control and
// the instruction hand-off to the consumer.
interface fetch_if;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_out;
    logic [31:0] imem_data_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misaligned;

    modport master (
        output imem_address, imem_read_write, imem_data_out,
        output inst_valid, inst, inst_pc, misaligned,
        input  imem_data_in, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  imem_address, imem_read_write, imem_data_out,
        input  inst_valid, inst, inst_pc, misaligned,
        output imem_data_in, redirect_valid, redirect_pc, halt, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC with a two-entry instruction buffer,
// redirect/flush, halt and a sticky misaligned-redirect flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset_n,
    fetch_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        head_inst_q, head_inst_d, head_pc_q, head_pc_d;
    logic [31:0]        tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;
    logic               misaligned_q, misaligned_d;

    logic               redir_c, bad_redir_c, pop_c, push_c;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: redirect outranks halt
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (redir_c)       state_d = bad_redir_c ? S_HALTED : S_FETCH;
                else if (bus.halt) state_d = S_HALTED;
                else               state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redir_c)       state_d = bad_redir_c ? S_HALTED : S_FETCH;
                else if (bus.halt) state_d = S_HALTED;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        redir_c     = bus.redirect_valid && (state_q != S_HALTED);
        bad_redir_c = redir_c && (bus.redirect_pc[1:0] != 2'b00);
        pop_c       = (count_q != '0) && bus.inst_ready;
        push_c      = (state_q == S_FETCH) && !bus.halt && !bus.redirect_valid &&
                      ((count_q < CNT_W'(BUF_DEPTH)) || pop_c);
    end

    // Buffer/PC next state; empty slots are kept zero so the head drives outputs directly
    always_comb begin
        pc_d         = pc_q;
        count_d      = count_q;
        head_inst_d  = head_inst_q;
        head_pc_d    = head_pc_q;
        tail_inst_d  = tail_inst_q;
        tail_pc_d    = tail_pc_q;
        misaligned_d = misaligned_q;

        if (redir_c) begin
            pc_d        = bus.redirect_pc;
            count_d     = '0;
            head_inst_d = '0;
            head_pc_d   = '0;
            tail_inst_d = '0;
            tail_pc_d   = '0;
            if (bad_redir_c) misaligned_d = 1'b1;
        end else begin
            if (push_c) pc_d = pc_q + 32'd4;
            unique case ({push_c, pop_c})
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        head_inst_d = bus.imem_data_in;
                        head_pc_d   = pc_q;
                    end else begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                        tail_inst_d = bus.imem_data_in;
                        tail_pc_d   = pc_q;
                    end
                end
                2'b10: begin
                    if (count_q == '0) begin
                        head_inst_d = bus.imem_data_in;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_inst_d = bus.imem_data_in;
                        tail_pc_d   = pc_q;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    head_inst_d = tail_inst_q;
                    head_pc_d   = tail_pc_q;
                    tail_inst_d = '0;
                    tail_pc_d   = '0;
                    count_d     = count_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            count_q      <= '0;
            head_inst_q  <= '0;
            head_pc_q    <= '0;
            tail_inst_q  <= '0;
            tail_pc_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_inst_q  <= head_inst_d;
            head_pc_q    <= head_pc_d;
            tail_inst_q  <= tail_inst_d;
            tail_pc_q    <= tail_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.imem_address    = pc_q;
    assign bus.imem_read_write = 1'b0;
    assign bus.imem_data_out   = 32'd0;
    assign bus.inst_valid      = (count_q != '0);
    assign bus.inst            = head_inst_q;
    assign bus.inst_pc         = head_pc_q;
    assign bus.misaligned      = misaligned_q;

endmodule
